// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths, R/W bit values and target FSM state encoding.
package i2c_pkg;
   localparam int I2C_ADDR_W = 7;
   localparam int I2C_BYTE_W = 8;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ADDR_ACK  = 3'd2,
      ST_WR_DATA   = 3'd3,
      ST_WR_ACK    = 3'd4,
      ST_RD_DATA   = 3'd5,
      ST_RD_ACK    = 3'd6,
      ST_WAIT_STOP = 3'd7
   } i2c_state_e;
endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one bus line, with the synchronized level and edge pulses.
module i2c_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);
   logic [1:0] sync_q;
   logic       prev_q;

   // Reset to the idle-bus level so leaving reset never fakes an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], line_i};
         prev_q <= sync_q[1];
      end
   end

   assign level_o = sync_q[1];
   assign rise_o  = sync_q[1] & ~prev_q;
   assign fall_o  = ~sync_q[1] & prev_q;
endmodule

// File: rtl/i2c_target.sv
// Single-address 7-bit I2C target: open-drain SDA, no clock stretching, byte-wide local interface.
// state     | meaning
// IDLE      | bus free, waiting for START
// ADDR      | shifting in address + R/W
// ADDR_ACK  | driving address ACK low
// WR_DATA   | shifting in a write byte
// WR_ACK    | driving data ACK low
// RD_DATA   | shifting out a read byte
// RD_ACK    | sampling master ACK/NACK
// WAIT_STOP | not addressed or NACKed; wait for STOP/START
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i2c_scl,
   inout  wire                   i2c_sda,
   input  logic [I2C_BYTE_W-1:0] tx_data,
   output logic                  tx_load,
   output logic [I2C_BYTE_W-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  rw,
   output logic                  busy
);
   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_sync u_scl_sync (
      .clk(clk), .rst(rst), .line_i(i2c_scl),
      .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
   );

   i2c_line_sync u_sda_sync (
      .clk(clk), .rst(rst), .line_i(i2c_sda),
      .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
   );

   i2c_state_e            state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [I2C_BYTE_W-1:0] shift_q, shift_d;
   logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
   logic                  sda_low_q, sda_low_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  tx_load_q, tx_load_d;
   logic                  rw_q, rw_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  start_evt, stop_evt;
   logic [I2C_BYTE_W-1:0] shift_in;

   assign start_evt = sda_fall & scl_lvl;
   assign stop_evt  = sda_rise & scl_lvl;
   assign shift_in  = {shift_q[I2C_BYTE_W-2:0], sda_lvl};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 3'd7;
         shift_q    <= '0;
         rx_data_q  <= '0;
         sda_low_q  <= 1'b0;
         rx_valid_q <= 1'b0;
         tx_load_q  <= 1'b0;
         rw_q       <= RW_WRITE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         sda_low_q  <= sda_low_d;
         rx_valid_q <= rx_valid_d;
         tx_load_q  <= tx_load_d;
         rw_q       <= rw_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // done_q marks "8th bit / ACK bit seen, act on the next SCL fall".
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      sda_low_d  = sda_low_q;
      rx_valid_d = 1'b0;
      tx_load_d  = 1'b0;
      rw_d       = rw_q;
      busy_d     = busy_q;
      done_d     = done_q;

      if (stop_evt) begin
         state_d   = ST_IDLE;
         sda_low_d = 1'b0;
         busy_d    = 1'b0;
         done_d    = 1'b0;
      end else if (start_evt) begin
         state_d   = ST_ADDR;
         cnt_d     = 3'd7;
         sda_low_d = 1'b0;
         busy_d    = 1'b0;
         done_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_ADDR: begin
               if (scl_rise) begin
                  shift_d = shift_in;
                  if (cnt_q == 3'd0) begin
                     if (shift_in[I2C_BYTE_W-1:1] == TARGET_ADDR) begin
                        rw_d   = shift_in[0];
                        busy_d = 1'b1;
                        done_d = 1'b1;
                     end else begin
                        state_d = ST_WAIT_STOP;
                     end
                  end else begin
                     cnt_d = cnt_q - 3'd1;
                  end
               end else if (scl_fall && done_q) begin
                  done_d    = 1'b0;
                  sda_low_d = 1'b1;
                  state_d   = ST_ADDR_ACK;
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  cnt_d = 3'd7;
                  if (rw_q == RW_READ) begin
                     shift_d   = tx_data;
                     tx_load_d = 1'b1;
                     sda_low_d = ~tx_data[I2C_BYTE_W-1];
                     state_d   = ST_RD_DATA;
                  end else begin
                     sda_low_d = 1'b0;
                     state_d   = ST_WR_DATA;
                  end
               end
            end
            ST_WR_DATA: begin
               if (scl_rise) begin
                  shift_d = shift_in;
                  if (cnt_q == 3'd0) begin
                     rx_data_d  = shift_in;
                     rx_valid_d = 1'b1;
                     done_d     = 1'b1;
                  end else begin
                     cnt_d = cnt_q - 3'd1;
                  end
               end else if (scl_fall && done_q) begin
                  done_d    = 1'b0;
                  sda_low_d = 1'b1;
                  state_d   = ST_WR_ACK;
               end
            end
            ST_WR_ACK: begin
               if (scl_fall) begin
                  sda_low_d = 1'b0;
                  cnt_d     = 3'd7;
                  state_d   = ST_WR_DATA;
               end
            end
            ST_RD_DATA: begin
               if (scl_fall) begin
                  if (cnt_q == 3'd0) begin
                     sda_low_d = 1'b0;
                     state_d   = ST_RD_ACK;
                  end else begin
                     shift_d   = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                     sda_low_d = ~shift_q[I2C_BYTE_W-2];
                     cnt_d     = cnt_q - 3'd1;
                  end
               end
            end
            ST_RD_ACK: begin
               if (scl_rise) begin
                  if (sda_lvl) state_d = ST_WAIT_STOP;
                  else         done_d  = 1'b1;
               end else if (scl_fall && done_q) begin
                  done_d    = 1'b0;
                  shift_d   = tx_data;
                  tx_load_d = 1'b1;
                  sda_low_d = ~tx_data[I2C_BYTE_W-1];
                  cnt_d     = 3'd7;
                  state_d   = ST_RD_DATA;
               end
            end
            ST_WAIT_STOP: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign i2c_sda  = sda_low_q ? 1'b0 : 1'bz;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_load  = tx_load_q;
   assign rw       = rw_q;
   assign busy     = busy_q;
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level bus master driving directed and random transfers,
// with a transaction-level expectation model and a per-cycle output monitor.
module tb_i2c_target;
   import i2c_pkg::*;

   localparam logic [6:0] TADDR = 7'h50;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       sda_low = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_load, rx_valid, rw, busy;
   logic [7:0] rx_data;
   wire        sda_bus;

   assign sda_bus = sda_low ? 1'b0 : 1'bz;
   pullup (sda_bus);

   i2c_target #(.TARGET_ADDR(TADDR)) dut (
      .clk(clk), .rst(rst), .i2c_scl(scl), .i2c_sda(sda_bus),
      .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
      .rx_valid(rx_valid), .rw(rw), .busy(busy)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_rx_q[$];
   int         exp_tx_loads = 0;
   int         act_tx_loads = 0;
   logic [7:0] last_rx = 8'h00;
   bit         quiet = 1'b1;
   logic [7:0] mon_exp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle monitor: pulse exclusivity, write-byte scoreboard, tx_load count, unaddressed SDA.
   always @(negedge clk) begin
      if (!rst) begin
         chk("rx_tx_overlap", {31'b0, rx_valid & tx_load}, 32'd0);
         if (rx_valid) begin
            checks++;
            if (exp_rx_q.size() == 0) begin
               errors++;
               $display("FAIL rx_valid_unexpected actual=%02h required=no_pulse", rx_data);
            end else begin
               mon_exp = exp_rx_q.pop_front();
               if (rx_data !== mon_exp) begin
                  errors++;
                  $display("FAIL rx_data actual=%02h required=%02h", rx_data, mon_exp);
               end
            end
         end
         if (tx_load) act_tx_loads++;
         chk("sda_quiet", {31'b0, quiet && (sda_bus === 1'b0) && !sda_low}, 32'd0);
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clk_bit(input logic drive_low, output logic smp);
      sda_low = drive_low;
      tick(6);
      scl = 1'b1;
      tick(4);
      smp = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
      tick(4);
      scl = 1'b0;
      tick(2);
   endtask

   task automatic do_start;
      sda_low = 1'b0;
      tick(4);
      scl = 1'b1;
      tick(6);
      sda_low = 1'b1;
      tick(6);
      scl = 1'b0;
      tick(2);
   endtask

   task automatic do_stop;
      sda_low = 1'b1;
      tick(4);
      scl = 1'b1;
      tick(6);
      sda_low = 1'b0;
      tick(3);
      chk("busy_after_stop", {31'b0, busy}, 32'd0);
      tick(3);
      quiet = 1'b1;
   endtask

   task automatic send_addr(input logic [6:0] a, input logic r);
      logic [7:0] b;
      logic       s;
      logic       m;
      b = {a, r};
      m = (a == TADDR);
      quiet = 1'b1;
      for (int i = 7; i >= 0; i--) clk_bit(!b[i], s);
      quiet = !m;
      clk_bit(1'b0, s);
      chk("addr_ack", {31'b0, !s}, {31'b0, m});
      chk("busy_addr", {31'b0, busy}, {31'b0, m});
      if (m) chk("rw", {31'b0, rw}, {31'b0, r});
      if (m && r) exp_tx_loads++;
   endtask

   task automatic write_byte(input logic [7:0] d, input logic m);
      logic s;
      if (m) begin
         exp_rx_q.push_back(d);
         last_rx = d;
      end
      for (int i = 7; i >= 0; i--) clk_bit(!d[i], s);
      clk_bit(1'b0, s);
      chk("wr_ack", {31'b0, !s}, {31'b0, m});
   endtask

   task automatic read_byte(input logic [7:0] exp, input logic [7:0] next_tx, input logic ack_it);
      logic [7:0] got;
      logic       s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b0, s);
         got[i] = s;
         if (i == 7) tx_data = next_tx;
      end
      chk("rd_byte", {24'b0, got}, {24'b0, exp});
      clk_bit(ack_it, s);
      if (ack_it) exp_tx_loads++;
   endtask

   task automatic end_checks;
      tick(2);
      chk("rx_pending", exp_rx_q.size(), 32'd0);
      chk("tx_load_count", act_tx_loads, exp_tx_loads);
      chk("rx_hold", {24'b0, rx_data}, {24'b0, last_rx});
   endtask

   initial begin
      logic       s;
      int         base;
      logic [7:0] d;

      tick(3);
      chk("rst_rx_data", {24'b0, rx_data}, 32'd0);
      chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
      chk("rst_tx_load", {31'b0, tx_load}, 32'd0);
      chk("rst_rw", {31'b0, rw}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_sda", {31'b0, sda_bus === 1'b0}, 32'd0);
      rst = 1'b0;
      tick(4);

      // Write 0xA5
      do_start;
      send_addr(TADDR, RW_WRITE);
      write_byte(8'hA5, 1'b1);
      chk("busy_write", {31'b0, busy}, 32'd1);
      do_stop;
      chk("write_literal", {24'b0, rx_data}, 32'h000000A5);
      end_checks;

      // Address mismatch
      do_start;
      send_addr(7'h51, RW_WRITE);
      write_byte(8'hFF, 1'b0);
      write_byte(8'h00, 1'b0);
      chk("busy_mismatch", {31'b0, busy}, 32'd0);
      do_stop;
      end_checks;

      // Two-byte read, ACK then NACK
      base = act_tx_loads;
      tx_data = 8'h3C;
      do_start;
      send_addr(TADDR, RW_READ);
      read_byte(8'h3C, 8'hC3, 1'b1);
      read_byte(8'hC3, 8'h99, 1'b0);
      chk("sda_after_nack", {31'b0, sda_bus === 1'b0}, 32'd0);
      do_stop;
      chk("tx_load_literal", act_tx_loads - base, 32'd2);
      end_checks;

      // Repeated START after 4 bits of a write byte, then read
      do_start;
      send_addr(TADDR, RW_WRITE);
      for (int i = 0; i < 4; i++) clk_bit(i[0], s);
      tx_data = 8'h5A;
      do_start;
      send_addr(TADDR, RW_READ);
      read_byte(8'h5A, 8'h00, 1'b0);
      do_stop;
      end_checks;

      // Reset while the target holds the address ACK low
      do_start;
      d = {TADDR, RW_WRITE};
      for (int i = 7; i >= 0; i--) clk_bit(!d[i], s);
      quiet = 1'b0;
      sda_low = 1'b0;
      tick(6);
      chk("ack_held", {31'b0, sda_bus === 1'b0}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_sda", {31'b0, sda_bus === 1'b0}, 32'd0);
      chk("rst_mid_busy", {31'b0, busy}, 32'd0);
      chk("rst_mid_rx_data", {24'b0, rx_data}, 32'd0);
      chk("rst_mid_rw", {31'b0, rw}, 32'd0);
      last_rx = 8'h00;
      quiet = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(4);
      do_start;
      send_addr(TADDR, RW_WRITE);
      write_byte(8'h6E, 1'b1);
      do_stop;
      end_checks;

      // STOP after 5 bits of a write byte
      do_start;
      send_addr(TADDR, RW_WRITE);
      write_byte(8'h81, 1'b1);
      for (int i = 0; i < 5; i++) clk_bit(!i[0], s);
      do_stop;
      chk("stop_partial_literal", {24'b0, rx_data}, 32'h00000081);
      end_checks;

      // Random transfers
      for (int it = 0; it < 20; it++) begin
         logic [6:0] a;
         logic       r;
         logic       m;
         int         n;
         logic [7:0] bytes [4];
         a = ($urandom_range(0, 1) == 1) ? TADDR : 7'($urandom);
         r = 1'($urandom);
         m = (a == TADDR);
         n = $urandom_range(1, 3);
         for (int k = 0; k < 4; k++) bytes[k] = 8'($urandom);
         tx_data = bytes[0];
         do_start;
         send_addr(a, r);
         if (!r) begin
            for (int k = 0; k < n; k++) write_byte(bytes[k], m);
            chk("busy_rand", {31'b0, busy}, {31'b0, m});
         end else if (m) begin
            for (int k = 0; k < n; k++)
               read_byte(bytes[k], (k < n - 1) ? bytes[k + 1] : 8'($urandom), k < n - 1);
         end
         do_stop;
         end_checks;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- Single-address I2C target (slave), 7-bit addressing, standard-mode byte framing; the bus-side counterpart of the team's I2C master.
- Fully synchronous to clk: oversamples SCL/SDA, detects START/STOP, ACKs its own address, receives write bytes and supplies read bytes through a byte-wide local interface.
- Open-drain SDA only; never stretches SCL.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit bus address this target responds to.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- i2c_scl  input  1  bus clock; sampled only, never driven.
- i2c_sda  inout  1  bus data; driven 0 or released (z), never driven 1.
- tx_data  input  8  byte to return on reads; captured when tx_load pulses.
- tx_load  output  1  one-clk pulse: tx_data captured into the shift register.
- rx_data  output  8  last byte received in a write transfer.
- rx_valid  output  1  one-clk pulse: rx_data updated.
- rw  output  1  R/W bit of the current addressed transfer (1 = read).
- busy  output  1  high while this target is addressed.

Behaviour:
- Reset (async): state IDLE, SDA released, rx_data=0, rx_valid=0, tx_load=0, rw=0, busy=0, bit counter=7. Takes effect mid-transfer immediately; a held ACK/data low is released in the same cycle.
- Input path: 2-flop synchronizer per line, then 1 registered edge detect; pin changes are visible 3 clk later. Each SCL high and low phase must last ≥4 clk; the team's master therefore runs DIVIDE_BY ≥ 16 when paired with this block.
- START: SDA fall while SCL high. STOP: SDA rise while SCL high. Both are recognised in every state and take priority over bit events in the same cycle.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- IDLE: START -> ADDR, counter=7. All other events ignored.
- ADDR: shift SDA in MSB-first on each SCL rise. After the 8th rise, compare bits[7:1] with TARGET_ADDR.
  - Match: latch rw=bit0, busy=1; at the next SCL fall drive SDA low -> ADDR_ACK.
  - Mismatch: -> WAIT_STOP, busy=0, SDA never driven.
- ADDR_ACK: hold SDA low through the ACK clock.
  - rw=0: release SDA at the next SCL fall -> WR_DATA.
  - rw=1: at the next SCL fall capture tx_data, pulse tx_load, drive bit7 -> RD_DATA.
- WR_DATA: sample on 8 SCL rises MSB-first. After the 8th rise, update rx_data and pulse rx_valid exactly once. Drive ACK low at the next fall -> WR_ACK. Release SDA at the following fall -> WR_DATA, counter=7. Every byte is ACKed; no back-pressure exists.
- RD_DATA: shift the next bit out on each SCL fall; bit value 1 = released. After bit0's clock, release SDA at the 8th fall -> RD_ACK.
- RD_ACK: sample the master's bit on the SCL rise.
  - 0 (ACK): at the next fall capture tx_data, pulse tx_load, drive bit7 -> RD_DATA.
  - 1 (NACK): -> WAIT_STOP, SDA released.
- WAIT_STOP: SDA released; wait for STOP or START.
- STOP in any state -> IDLE, SDA released, busy=0; any partial byte is discarded with no rx_valid.
- Repeated START in any state -> ADDR, counter=7, SDA released, busy=0 until the next address match; any partial byte is discarded.
- rx_valid and tx_load never assert in the same cycle; each is at most 1 pulse per byte.

Decomposition:
- Package i2c_pkg holds:
  - state encoding localparams;
  - I2C_ADDR_W=7 and I2C_BYTE_W=8;
  - the RW_WRITE=0 and RW_READ=1 constants, shared with the master.
- Sub-module i2c_line_sync, instantiated once per line: 2-flop synchronizer plus rise/fall pulse outputs and the synchronized level.

Test Plan:
- Write: START, addr 0x50 W, data 0xA5, STOP -> SDA low on both ACK clocks, rx_data=0xA5, one rx_valid pulse, busy 1 then 0 within 3 clk after STOP.
- Mismatch: START, addr 0x51 W, byte 0xFF -> SDA never driven low, no rx_valid, busy stays 0, state WAIT_STOP until STOP.
- Read: tx_data=0x3C, changed to 0xC3 after the first tx_load; master reads 2 bytes, ACKs the first and NACKs the second -> bus bits 0x3C then 0xC3, exactly 2 tx_load pulses, SDA released after the NACK.
- Repeated START after 4 bits of a write byte, then addr 0x50 R -> partial byte dropped (no rx_valid), rw=1, address ACKed.
- rst pulsed while the target drives an ACK low -> SDA released in the same cycle, all outputs at reset values, next START/addr 0x50 ACKed normally.
- STOP after 5 bits of a write byte -> IDLE, no rx_valid, rx_data keeps its previous value.
